// File: rtl/regfile_pkg.sv
// Shared constants and write-source priority for the register file.
// The bus write port outranks the ALU write-back port.
package regfile_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_REG_COUNT = 4;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_BUS  = 2'd1,
        SRC_ALU  = 2'd2
    } wr_src_e;

    // Both enables are active-low; the bus wins when both are asserted.
    function automatic wr_src_e wr_src_sel(input logic bus_nwe, input logic alu_nwe);
        if (!bus_nwe)
            return SRC_BUS;
        else if (!alu_nwe)
            return SRC_ALU;
        else
            return SRC_NONE;
    endfunction

endpackage

// File: rtl/regfile_incdec.sv
// Combinational increment/decrement of one register value.
// The wrap flag marks an increment from all-ones or a decrement from zero.
module regfile_incdec #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic             dec,
    output logic [WIDTH-1:0] next_value,
    output logic             wrap
);

    always_comb begin
        next_value = value + WIDTH'(1);
        wrap       = &value;
        if (dec) begin
            next_value = value - WIDTH'(1);
            wrap       = ~|value;
        end
    end

endmodule

// File: rtl/regfile_n.sv
// REG_COUNT x WIDTH register file: bus/ALU addressed writes, two ALU read
// ports, one bus read port and in-place inc/dec with a registered wrap flag.
module regfile_n
    import regfile_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int REG_COUNT = DEFAULT_REG_COUNT,
    parameter int ADDR_W    = $clog2(REG_COUNT)
) (
    input  logic                       i_clk,
    input  logic                       i_nReset,
    input  logic [WIDTH-1:0]           i_bus,
    output logic [WIDTH-1:0]           o_bus,
    output logic                       o_busNOE,
    input  logic                       i_ctrlBusNWE,
    input  logic                       i_ctrlAluNWE,
    input  logic [ADDR_W-1:0]          i_ctrlWrAddr,
    input  logic [WIDTH-1:0]           i_aluResult,
    input  logic [ADDR_W-1:0]          i_ctrlAluSelA,
    input  logic [ADDR_W-1:0]          i_ctrlAluSelB,
    output logic [WIDTH-1:0]           o_aluA,
    output logic [WIDTH-1:0]           o_aluB,
    input  logic [ADDR_W-1:0]          i_ctrlBusSel,
    input  logic                       i_ctrlBusNOE,
    input  logic                       i_ctrlIncNE,
    input  logic                       i_ctrlDecNE,
    input  logic [ADDR_W-1:0]          i_ctrlIdAddr,
    output logic                       o_idWrap,
    output logic [REG_COUNT*WIDTH-1:0] o_dbgRegs
);

    logic [WIDTH-1:0] regs [REG_COUNT];
    logic             id_wrap;

    wr_src_e          wr_src;
    logic [WIDTH-1:0] wr_data;
    logic             wr_in_range;
    logic             wr_en;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] bus_rd;
    logic [WIDTH-1:0] id_cur;
    logic             id_in_range;
    logic             id_req;
    logic             id_en;
    logic [WIDTH-1:0] id_next;
    logic             id_wrap_next;

    // Selects that match no register leave the defaults, so out-of-range reads give 0.
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        bus_rd      = '0;
        id_cur      = '0;
        wr_in_range = 1'b0;
        id_in_range = 1'b0;
        for (int k = 0; k < REG_COUNT; k++) begin
            if (i_ctrlAluSelA == ADDR_W'(k)) alu_a = regs[k];
            if (i_ctrlAluSelB == ADDR_W'(k)) alu_b = regs[k];
            if (i_ctrlBusSel  == ADDR_W'(k)) bus_rd = regs[k];
            if (i_ctrlIdAddr  == ADDR_W'(k)) begin
                id_cur      = regs[k];
                id_in_range = 1'b1;
            end
            if (i_ctrlWrAddr == ADDR_W'(k)) wr_in_range = 1'b1;
        end
    end

    always_comb begin
        wr_src  = wr_src_sel(i_ctrlBusNWE, i_ctrlAluNWE);
        wr_data = '0;
        case (wr_src)
            SRC_BUS: wr_data = i_bus;
            SRC_ALU: wr_data = i_aluResult;
            default: wr_data = '0;
        endcase
        wr_en  = (wr_src != SRC_NONE) && wr_in_range;
        id_req = i_ctrlIncNE ^ i_ctrlDecNE;
        // A write to the same register discards the inc/dec entirely, wrap flag included.
        id_en  = id_req && id_in_range && !(wr_en && (i_ctrlWrAddr == i_ctrlIdAddr));
    end

    regfile_incdec #(
        .WIDTH(WIDTH)
    ) u_incdec (
        .value      (id_cur),
        .dec        (~i_ctrlDecNE),
        .next_value (id_next),
        .wrap       (id_wrap_next)
    );

    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            for (int k = 0; k < REG_COUNT; k++) regs[k] <= '0;
            id_wrap <= 1'b0;
        end else begin
            for (int k = 0; k < REG_COUNT; k++) begin
                if (wr_en && (i_ctrlWrAddr == ADDR_W'(k)))
                    regs[k] <= wr_data;
                else if (id_en && (i_ctrlIdAddr == ADDR_W'(k)))
                    regs[k] <= id_next;
            end
            if (id_en) id_wrap <= id_wrap_next;
        end
    end

    assign o_aluA   = alu_a;
    assign o_aluB   = alu_b;
    assign o_bus    = i_ctrlBusNOE ? '0 : bus_rd;
    assign o_busNOE = i_ctrlBusNOE;
    assign o_idWrap = id_wrap;

    for (genvar k = 0; k < REG_COUNT; k++) begin : g_dbg
        assign o_dbgRegs[k*WIDTH +: WIDTH] = regs[k];
    end

endmodule

// File: tb/tb_regfile_n.sv
// Scoreboard bench for regfile_n with three 8-bit registers (non-power-of-two,
// so select value 3 is out of range). Expectations come from an array model.
module tb_regfile_n;

    localparam int W  = 8;
    localparam int RC = 3;
    localparam int AW = 2;

    logic              i_clk = 1'b0;
    logic              i_nReset;
    logic [W-1:0]      i_bus;
    logic [W-1:0]      o_bus;
    logic              o_busNOE;
    logic              i_ctrlBusNWE;
    logic              i_ctrlAluNWE;
    logic [AW-1:0]     i_ctrlWrAddr;
    logic [W-1:0]      i_aluResult;
    logic [AW-1:0]     i_ctrlAluSelA;
    logic [AW-1:0]     i_ctrlAluSelB;
    logic [W-1:0]      o_aluA;
    logic [W-1:0]      o_aluB;
    logic [AW-1:0]     i_ctrlBusSel;
    logic              i_ctrlBusNOE;
    logic              i_ctrlIncNE;
    logic              i_ctrlDecNE;
    logic [AW-1:0]     i_ctrlIdAddr;
    logic              o_idWrap;
    logic [RC*W-1:0]   o_dbgRegs;

    regfile_n #(.WIDTH(W), .REG_COUNT(RC), .ADDR_W(AW)) dut (
        .i_clk(i_clk), .i_nReset(i_nReset),
        .i_bus(i_bus), .o_bus(o_bus), .o_busNOE(o_busNOE),
        .i_ctrlBusNWE(i_ctrlBusNWE), .i_ctrlAluNWE(i_ctrlAluNWE),
        .i_ctrlWrAddr(i_ctrlWrAddr), .i_aluResult(i_aluResult),
        .i_ctrlAluSelA(i_ctrlAluSelA), .i_ctrlAluSelB(i_ctrlAluSelB),
        .o_aluA(o_aluA), .o_aluB(o_aluB),
        .i_ctrlBusSel(i_ctrlBusSel), .i_ctrlBusNOE(i_ctrlBusNOE),
        .i_ctrlIncNE(i_ctrlIncNE), .i_ctrlDecNE(i_ctrlDecNE),
        .i_ctrlIdAddr(i_ctrlIdAddr), .o_idWrap(o_idWrap),
        .o_dbgRegs(o_dbgRegs)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rst_n;
        logic        bus_nwe;
        logic [7:0]  bus;
        logic        alu_nwe;
        logic [7:0]  alu;
        logic [1:0]  wr_addr;
        logic [1:0]  sel_a;
        logic [1:0]  sel_b;
        logic [1:0]  bus_sel;
        logic        bus_noe;
        logic        inc_ne;
        logic        dec_ne;
        logic [1:0]  id_addr;
    } stim_t;

    typedef struct {
        int a;
        int b;
        int bus;
        int noe;
        int dbg;
        int wrap;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   n_tests = 0;
    int   n_fail  = 0;

    int   m[RC];
    int   m_wrap;

    function automatic int rd(input int a);
        return (a < RC) ? m[a] : 0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rst_n   = 1'b1;
        s.bus_nwe = 1'b1;
        s.bus     = 8'($urandom);
        s.alu_nwe = 1'b1;
        s.alu     = 8'($urandom);
        s.wr_addr = 2'($urandom);
        s.sel_a   = 2'($urandom);
        s.sel_b   = 2'($urandom);
        s.bus_sel = 2'($urandom);
        s.bus_noe = 1'($urandom);
        s.inc_ne  = 1'b1;
        s.dec_ne  = 1'b1;
        s.id_addr = 2'($urandom);
        return s;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        int   inc_a, dec_a, wr, wd, id, v;
        @(negedge i_clk);
        i_nReset      = s.rst_n;
        i_ctrlBusNWE  = s.bus_nwe;
        i_bus         = s.bus;
        i_ctrlAluNWE  = s.alu_nwe;
        i_aluResult   = s.alu;
        i_ctrlWrAddr  = s.wr_addr;
        i_ctrlAluSelA = s.sel_a;
        i_ctrlAluSelB = s.sel_b;
        i_ctrlBusSel  = s.bus_sel;
        i_ctrlBusNOE  = s.bus_noe;
        i_ctrlIncNE   = s.inc_ne;
        i_ctrlDecNE   = s.dec_ne;
        i_ctrlIdAddr  = s.id_addr;
        if (!s.rst_n) begin
            for (int k = 0; k < RC; k++) m[k] = 0;
            m_wrap = 0;
        end
        e.a    = rd(int'(s.sel_a));
        e.b    = rd(int'(s.sel_b));
        e.bus  = s.bus_noe ? 0 : rd(int'(s.bus_sel));
        e.noe  = int'(s.bus_noe);
        e.dbg  = m[0] + 256 * m[1] + 65536 * m[2];
        e.wrap = m_wrap;
        exp_q.push_back(e);
        #1 -> sample_ev;
        if (s.rst_n) begin
            wr    = ((!s.bus_nwe || !s.alu_nwe) && int'(s.wr_addr) < RC) ? 1 : 0;
            wd    = !s.bus_nwe ? int'(s.bus) : int'(s.alu);
            inc_a = s.inc_ne ? 0 : 1;
            dec_a = s.dec_ne ? 0 : 1;
            id    = int'(s.id_addr);
            if ((inc_a != dec_a) && id < RC && !(wr == 1 && int'(s.wr_addr) == id)) begin
                v = m[id];
                if (inc_a == 1) begin
                    m[id]  = (v + 1) % 256;
                    m_wrap = (v == 255) ? 1 : 0;
                end else begin
                    m[id]  = (v + 255) % 256;
                    m_wrap = (v == 0) ? 1 : 0;
                end
            end
            if (wr == 1) m[int'(s.wr_addr)] = wd;
        end
    endtask

    // Monitor: pops one expectation per sample strobe and compares every output.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("o_aluA",    int'(o_aluA),    e.a);
                chk("o_aluB",    int'(o_aluB),    e.b);
                chk("o_bus",     int'(o_bus),     e.bus);
                chk("o_busNOE",  int'(o_busNOE),  e.noe);
                chk("o_dbgRegs", int'(o_dbgRegs), e.dbg);
                chk("o_idWrap",  int'(o_idWrap),  e.wrap);
            end
        end
    end

    initial begin
        stim_t s;
        i_nReset = 1'b0;
        for (int k = 0; k < RC; k++) m[k] = 0;
        m_wrap = 0;

        s = idle(); s.rst_n = 1'b0; step(s);
        s = idle(); s.rst_n = 1'b0; step(s);

        // Bus write then ALU write, then read back through all ports.
        s = idle(); s.bus_nwe = 0; s.bus = 8'hA5; s.wr_addr = 2; step(s);
        s = idle(); s.alu_nwe = 0; s.alu = 8'h3C; s.wr_addr = 0; step(s);
        s = idle(); s.sel_a = 2; s.sel_b = 0; s.bus_sel = 2; s.bus_noe = 0; step(s);
        s = idle(); s.bus_sel = 2; s.bus_noe = 1; step(s);

        // Simultaneous bus and ALU writes: bus wins.
        s = idle(); s.bus_nwe = 0; s.alu_nwe = 0; s.bus = 8'h11; s.alu = 8'h22; s.wr_addr = 1; step(s);
        s = idle(); s.sel_a = 1; step(s);

        // Wrap on increment and decrement.
        s = idle(); s.bus_nwe = 0; s.bus = 8'hFF; s.wr_addr = 0; step(s);
        s = idle(); s.inc_ne = 0; s.id_addr = 0; step(s);
        s = idle(); s.inc_ne = 0; s.id_addr = 0; step(s);
        s = idle(); s.dec_ne = 0; s.id_addr = 0; step(s);
        s = idle(); s.dec_ne = 0; s.id_addr = 0; step(s);
        s = idle(); step(s);

        // Same-target write beats inc; different targets both apply.
        s = idle(); s.inc_ne = 0; s.id_addr = 1; s.bus_nwe = 0; s.bus = 8'h40; s.wr_addr = 1; step(s);
        s = idle(); s.inc_ne = 0; s.id_addr = 1; s.bus_nwe = 0; s.bus = 8'h77; s.wr_addr = 0; step(s);

        // Out-of-range write/read/inc and inc+dec together.
        s = idle(); s.bus_nwe = 0; s.bus = 8'hEE; s.wr_addr = 3; s.sel_a = 3; s.bus_sel = 3; s.bus_noe = 0; step(s);
        s = idle(); s.inc_ne = 0; s.dec_ne = 0; s.id_addr = 2; step(s);
        s = idle(); s.inc_ne = 0; s.id_addr = 3; s.sel_b = 3; step(s);
        s = idle(); step(s);

        // Reset asserted between edges while increments are running.
        s = idle(); s.inc_ne = 0; s.id_addr = 2; step(s);
        @(posedge i_clk);
        #2;
        i_nReset = 1'b0;
        for (int k = 0; k < RC; k++) m[k] = 0;
        m_wrap = 0;
        begin
            exp_t e;
            e.a = 0; e.b = 0; e.bus = 0; e.noe = int'(i_ctrlBusNOE); e.dbg = 0; e.wrap = 0;
            exp_q.push_back(e);
        end
        #1 -> sample_ev;
        s = idle(); s.rst_n = 0; s.inc_ne = 0; s.id_addr = 2; step(s);
        s = idle(); s.rst_n = 0; s.bus_nwe = 0; s.wr_addr = 1; step(s);
        s = idle(); s.inc_ne = 0; s.id_addr = 2; step(s);
        s = idle(); step(s);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            s = idle();
            s.rst_n   = ($urandom_range(0, 60) != 0);
            s.bus_nwe = ($urandom_range(0, 2) != 0);
            s.alu_nwe = ($urandom_range(0, 2) != 0);
            s.inc_ne  = ($urandom_range(0, 1) != 0);
            s.dec_ne  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) s.bus = 8'hFF;
            if ($urandom_range(0, 3) == 0) s.alu = 8'h00;
            step(s);
        end

        @(negedge i_clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
